brightness_controller: RTL
==========================

// Module: brightness_controller
// PURPOSE
//  Turns the debounced increase/decrease button levels into a saturating brightness level,
//  with press-and-hold auto-repeat.
//  Gates the debounced 8-bit colour switches with a PWM derived from that level to drive the LEDs.
//  Sits directly downstream of the debouncer; everything runs in the single system clock domain.
// PARAMETERS
//  LEVEL_W        4    width of brightness level and PWM counter
//  MAX_LEVEL      15   upper level bound (must be <= 2**LEVEL_W-1)
//  RESET_LEVEL    8    level loaded on reset (must be <= MAX_LEVEL)
//  HOLD_CYCLES    50000000  clk cycles a button is held before auto-repeat starts (>=2)
//  REPEAT_CYCLES  10000000  clk cycles between auto-repeat steps (>=2)
// PORTS
//  clk        in   1        system clock, rising edge
//  reset      in   1        asynchronous, active-high reset
//  increase   in   1        debounced increase button level (1 = pressed)
//  decrease   in   1        debounced decrease button level (1 = pressed)
//  color_in   in   8        debounced colour switch vector
//  level      out  LEVEL_W  current brightness level
//  step       out  1        one-cycle pulse in the cycle level changes
//  led        out  8        colour gated by PWM
// BEHAVIOUR
//  Reset (async, active-high):
//   - level=RESET_LEVEL, step=0, led=0.
//   - FSM=IDLE; hold counter, PWM counter and colour register all 0.
//  FSM states: IDLE, DELAY, REPEAT, LOCK. All checks below sample the inputs on each rising clk edge.
//   IDLE:
//    - increase^decrease: apply one step in the pressed direction, latch that direction,
//      clear the hold counter, go DELAY.
//    - both high: go LOCK, no step.
//    - neither high: stay in IDLE.
//   DELAY:
//    - Both buttons high: go LOCK, no step.
//    - Else latched button released: go IDLE, no step.
//    - Else counter==HOLD_CYCLES-1: step, clear counter, go REPEAT.
//    - Otherwise increment the counter.
//   REPEAT:
//    - Same release/both checks as DELAY.
//    - Counter==REPEAT_CYCLES-1: step, clear counter, stay in REPEAT.
//   LOCK:
//    - No stepping.
//    - Go IDLE only when increase==0 and decrease==0.
//  Step timing:
//   - level and step are registered.
//   - A press sampled at edge N updates level at edge N, visible after edge N.
//   - Latency from press to new level is 1 clk.
//  Arithmetic:
//   - Increase saturates at MAX_LEVEL; decrease saturates at 0.
//   - A step attempted at a bound leaves level unchanged and step=0.
//  Direction switch while holding:
//   - The latched direction only changes via IDLE.
//   - Releasing A and pressing B in the same cycle: go IDLE; B steps on the next edge.
//  PWM:
//   - Free-running LEVEL_W-bit counter pwm_cnt, wraps at 2**LEVEL_W-1 -> 0.
//   - pwm_on = (level==MAX_LEVEL) | (pwm_cnt < level). level 0 keeps led at 0.
//   - color_q <= color_in every cycle.
//   - led <= color_q & {8{pwm_on}}: registered, 2-cycle latency from color_in.
//  Reset mid-hold: FSM returns to IDLE immediately. After reset deasserts, a still-held single
//  button restarts as a fresh press (one step on the first edge).
// CONFIGURATION
//  LEVEL_WRAP_EN defined:
//   - increase at MAX_LEVEL wraps to 0; decrease at 0 wraps to MAX_LEVEL.
//   - step pulses on every wrap.
//  LEVEL_WRAP_EN undefined: saturating behaviour as above (default build).
// TESTING (bench uses LEVEL_W=4, MAX_LEVEL=15, RESET_LEVEL=8, HOLD_CYCLES=4, REPEAT_CYCLES=2)
//  1. Reset, idle 20 cycles -> level=8, step never high.
//  2. Pulse increase for 1 cycle -> level=9 one cycle later, exactly one step pulse.
//  3. Hold increase 10 cycles:
//     - Expected level sequence 9 (edge 1), 10 (edge 5), 11 (edge 7), 12 (edge 9).
//     - Release -> no further steps.
//  4. Drive level to 15, then press increase -> level stays 15, step=0.
//     With LEVEL_WRAP_EN: level=0, step=1.
//  5. Hold increase, then assert decrease -> no step, FSM=LOCK.
//     Release decrease only -> still no step. Release both, press decrease -> level-1.
//  6. color_in=8'hA5, level=4 -> led=8'hA5 for 4 of every 16 cycles, else 0.
//     level=0 -> led=0 always; level=15 -> led=8'hA5 constantly.
//     Async reset mid-REPEAT -> led=0 and level=8 without waiting for a clock edge.

Source files
------------

// File: rtl/brightness_controller.sv
// Brightness level from debounced up/down buttons with press-and-hold auto-repeat, and a PWM gate on the colour LEDs.
// Define LEVEL_WRAP_EN to make the level wrap at its bounds instead of saturating.
module brightness_controller #(
  parameter int LEVEL_W       = 4,
  parameter int MAX_LEVEL     = 15,
  parameter int RESET_LEVEL   = 8,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               increase,
  input  logic               decrease,
  input  logic [7:0]         color_in,
  output logic [LEVEL_W-1:0] level,
  output logic               step,
  output logic [7:0]         led
);

  localparam int MAX_CYC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT, S_LOCK} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dir_up_q, dir_up_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               step_q, step_d;
  logic [LEVEL_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [7:0]         color_q;
  logic [7:0]         led_q, led_d;

  logic               both_pressed;
  logic               held_pressed;
  logic [CNT_W-1:0]   cnt_limit;
  logic               step_req;
  logic               step_up;
  logic               pwm_on;

  always_comb begin
    both_pressed = increase & decrease;
    held_pressed = dir_up_q ? increase : decrease;
    cnt_limit    = (state_q == S_DELAY) ? CNT_W'(HOLD_CYCLES - 1) : CNT_W'(REPEAT_CYCLES - 1);
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      dir_up_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dir_up_q <= dir_up_d;
    end
  end

  // FSM next state; the both-pressed check outranks release so a chord always locks
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dir_up_d = dir_up_q;
    case (state_q)
      S_IDLE: begin
        if (increase ^ decrease) begin
          state_d  = S_DELAY;
          dir_up_d = increase;
          cnt_d    = '0;
        end else if (both_pressed) begin
          state_d = S_LOCK;
        end
      end
      S_DELAY, S_REPEAT: begin
        if (both_pressed) begin
          state_d = S_LOCK;
        end else if (!held_pressed) begin
          state_d = S_IDLE;
        end else if (cnt_q == cnt_limit) begin
          state_d = S_REPEAT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        if (!increase && !decrease) state_d = S_IDLE;
      end
    endcase
  end

  // FSM outputs: step request and its direction
  always_comb begin
    step_req = 1'b0;
    step_up  = dir_up_q;
    case (state_q)
      S_IDLE: begin
        step_req = increase ^ decrease;
        step_up  = increase;
      end
      S_DELAY, S_REPEAT: begin
        step_req = !both_pressed && held_pressed && (cnt_q == cnt_limit);
      end
      default: step_req = 1'b0;
    endcase
  end

  always_comb begin
    level_d = level_q;
    step_d  = 1'b0;
    if (step_req) begin
      if (step_up) begin
        if (level_q != LEVEL_W'(MAX_LEVEL)) begin
          level_d = level_q + LEVEL_W'(1);
          step_d  = 1'b1;
        end
`ifdef LEVEL_WRAP_EN
        else begin
          level_d = '0;
          step_d  = 1'b1;
        end
`endif
      end else begin
        if (level_q != '0) begin
          level_d = level_q - LEVEL_W'(1);
          step_d  = 1'b1;
        end
`ifdef LEVEL_WRAP_EN
        else begin
          level_d = LEVEL_W'(MAX_LEVEL);
          step_d  = 1'b1;
        end
`endif
      end
    end
  end

  // Full level forces the LEDs on so MAX_LEVEL is truly 100% duty
  always_comb begin
    pwm_on    = (level_q == LEVEL_W'(MAX_LEVEL)) || (pwm_cnt_q < level_q);
    pwm_cnt_d = pwm_cnt_q + LEVEL_W'(1);
    led_d     = color_q & {8{pwm_on}};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q   <= LEVEL_W'(RESET_LEVEL);
      step_q    <= 1'b0;
      pwm_cnt_q <= '0;
      color_q   <= '0;
      led_q     <= '0;
    end else begin
      level_q   <= level_d;
      step_q    <= step_d;
      pwm_cnt_q <= pwm_cnt_d;
      color_q   <= color_in;
      led_q     <= led_d;
    end
  end

  assign level = level_q;
  assign step  = step_q;
  assign led   = led_q;

endmodule
